countdown_controller: RTL and testbench
=======================================

Name: countdown_controller

Overview:
- FSM that sequences the seconds countdown datapath: the down-counter register, the 1 s prescaler and the finished LED.
- Drives load/enable to the datapath and restarts the prescaler so every displayed second is full length.
- Adds pause/resume, abort and multi-round runs (N back-to-back countdowns).
- Sits between board switches/keys and the regressive counter datapath in the top level.

Parameters:
ROUNDS_WIDTH, 4, width of the rounds input and rounds_left counter.
DONE_HOLD_TICKS, 2, number of 1 s ticks ledr9_finished stays high in DONE before leaving; legal range 1..15.

Ports:
clock  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high; returns block to IDLE.
start  in  1  level from switch/key; action on rising edge only.
pause  in  1  level; high suspends counting.
abort  in  1  level; sampled every cycle; high cancels run.
rounds  in  ROUNDS_WIDTH  countdowns per run; 0 treated as 1; sampled only when run starts.
tick  in  1  one-cycle pulse per second from prescaler.
count_zero  in  1  datapath count value == 0.
count_load  out  1  datapath loads seconds_period this cycle.
count_enable  out  1  datapath decrements on tick when high.
tick_clear  out  1  synchronous clear of prescaler.
rounds_left  out  ROUNDS_WIDTH  rounds remaining, including the current one.
busy  out  1  high in LOAD, RUN, PAUSED, ROUND_END.
ledr9_finished  out  1  high only in DONE.
db_state  out  3  state encoding, for debug display.

Behaviour:
- Reset values: state IDLE, count_load=1, tick_clear=1, count_enable=0, busy=0, ledr9_finished=0, rounds_left=0, db_state=0, hold counter=0, start_q=1.
- start_q initialises to 1, so a start held high through reset does not trigger. A low-to-high transition is required.
- Start edge: start_rise = start & ~start_q; start_q registered every cycle.
- All outputs are a pure decode of the registered state and counters.
- Priority in every state: reset > abort > pause > tick/start.
- States and encodings: IDLE=0, LOAD=1, RUN=2, PAUSED=3, ROUND_END=4, DONE=5. Codes 6-7 are illegal and go to IDLE on the next cycle.
- IDLE:
  - count_load=1 and tick_clear=1 held, so the display shows seconds_period.
  - start_rise -> rounds_left <= (rounds==0 ? 1 : rounds), go LOAD.
  - abort high blocks start.
- LOAD (one cycle):
  - count_load=1, tick_clear=1.
  - -> RUN.
- RUN:
  - count_enable=1.
  - abort -> IDLE.
  - else pause -> PAUSED.
  - else (tick & count_zero) -> ROUND_END. Zero is therefore displayed for one full second.
  - else tick -> stay; the datapath decrements.
- PAUSED:
  - count_enable=0, tick_clear=1 (prescaler held), ticks ignored.
  - abort -> IDLE.
  - pause low -> RUN; the first second after resume is full length.
- ROUND_END (one cycle):
  - rounds_left <= rounds_left-1.
  - If rounds_left==1 -> DONE (rounds_left becomes 0); else -> LOAD.
- DONE:
  - ledr9_finished=1, count_enable=0, count_load=0. The datapath holds 0.
  - Hold counter cleared on entry, incremented on each tick.
  - When the counter reaches DONE_HOLD_TICKS-1 and tick=1 -> exit (see Optional Feature).
  - start_rise -> reload rounds_left from rounds, go LOAD.
  - abort -> IDLE.
- Start: start_rise outside IDLE/DONE is ignored, but start_q still tracks.
- seconds_period=0: the first tick in RUN ends the round.
- Reset mid-run: next cycle IDLE with reset values; no residual pulses.
- Simultaneous pause and tick&count_zero in RUN: pause wins, and the round does not end.

Optional Feature:
- Macro: COUNTDOWN_AUTO_REPEAT_EN.
- Defined: DONE hold expiry -> rounds_left reloaded from rounds, go LOAD. The block loops indefinitely until abort or reset.
- Not defined: DONE hold expiry -> IDLE.
- All other behaviour identical.

Test Plan:
- Run: rounds=2, seconds_period=3 (model datapath in bench), start edge -> LOAD 1 cycle; display 3,2,1,0 at 1 tick each, twice. ROUND_END seen twice, rounds_left 2->1->0. DONE with ledr9_finished=1 for exactly 2 ticks, then IDLE (macro off).
- Start during reset: start held high through reset, released low, raised high -> no run until the low-to-high edge. Then LOAD exactly 1 cycle after the edge.
- Pause at count 2: tick_clear=1, count_enable=0; 5 ticks ignored. Release -> RUN; next decrement only after a full prescaler period. Pause on the same cycle as tick&count_zero -> PAUSED, no ROUND_END.
- Abort in RUN, PAUSED and DONE -> IDLE next cycle, count_load=1, busy=0, ledr9_finished=0. rounds=0 then start -> exactly one round.
- Zero period: seconds_period=0, rounds=1 -> ROUND_END on the first tick, DONE. start_rise in DONE -> immediate new run via LOAD.
- COUNTDOWN_AUTO_REPEAT_EN defined: rounds=1, period=1 -> DONE -> LOAD after 2 ticks, repeats 3 times. Abort ends the loop.

Source files
------------

// File: rtl/countdown_controller.sv
// Countdown sequencer: load/enable of the seconds counter,
// prescaler restart, pause/abort and multi-round runs.
// Optional: COUNTDOWN_AUTO_REPEAT_EN restarts the run after DONE.
module countdown_controller #(
  parameter int ROUNDS_WIDTH    = 4,
  parameter int DONE_HOLD_TICKS = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    abort,
  input  logic [ROUNDS_WIDTH-1:0] rounds,
  input  logic                    tick,
  input  logic                    count_zero,
  output logic                    count_load,
  output logic                    count_enable,
  output logic                    tick_clear,
  output logic [ROUNDS_WIDTH-1:0] rounds_left,
  output logic                    busy,
  output logic                    ledr9_finished,
  output logic [2:0]              db_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RUN       = 3'd2,
    PAUSED    = 3'd3,
    ROUND_END = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [ROUNDS_WIDTH-1:0] ONE = 1;
  localparam logic [3:0] HOLD_LAST = 4'(DONE_HOLD_TICKS - 1);

  state_t                  state;
  logic [3:0]              hold;
  logic                    start_q;
  logic                    start_rise;
  logic [ROUNDS_WIDTH-1:0] rounds_init;

  assign start_rise  = start & ~start_q;
  assign rounds_init = (rounds == '0) ? ONE : rounds;

  // Sequencing of the countdown run; abort always wins over pause/tick/start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rounds_left <= '0;
      hold        <= '0;
      start_q     <= 1'b1;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (!abort && start_rise) begin
            rounds_left <= rounds_init;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            rounds_left <= '0;
            state       <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            rounds_left <= '0;
            state       <= IDLE;
          end else if (pause) begin
            state <= PAUSED;
          end else if (tick && count_zero) begin
            state <= ROUND_END;
          end
        end
        PAUSED: begin
          if (abort) begin
            rounds_left <= '0;
            state       <= IDLE;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        ROUND_END: begin
          if (abort) begin
            rounds_left <= '0;
            state       <= IDLE;
          end else begin
            rounds_left <= rounds_left - ONE;
            hold        <= '0;
            state       <= (rounds_left == ONE) ? DONE : LOAD;
          end
        end
        DONE: begin
          if (abort) begin
            rounds_left <= '0;
            hold        <= '0;
            state       <= IDLE;
          end else if (start_rise) begin
            rounds_left <= rounds_init;
            hold        <= '0;
            state       <= LOAD;
          end else if (tick) begin
            if (hold == HOLD_LAST) begin
              hold <= '0;
`ifdef COUNTDOWN_AUTO_REPEAT_EN
              rounds_left <= rounds_init;
              state       <= LOAD;
`else
              state       <= IDLE;
`endif
            end else begin
              hold <= hold + 4'd1;
            end
          end
        end
        default: begin
          rounds_left <= '0;
          hold        <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    count_load     = 1'b0;
    count_enable   = 1'b0;
    tick_clear     = 1'b0;
    busy           = 1'b0;
    ledr9_finished = 1'b0;
    case (state)
      IDLE: begin
        count_load = 1'b1;
        tick_clear = 1'b1;
      end
      LOAD: begin
        count_load = 1'b1;
        tick_clear = 1'b1;
        busy       = 1'b1;
      end
      RUN: begin
        count_enable = 1'b1;
        busy         = 1'b1;
      end
      PAUSED: begin
        tick_clear = 1'b1;
        busy       = 1'b1;
      end
      ROUND_END: begin
        busy = 1'b1;
      end
      DONE: begin
        ledr9_finished = 1'b1;
      end
      default: begin
        count_load = 1'b1;
        tick_clear = 1'b1;
      end
    endcase
  end

  assign db_state = state;

endmodule

// File: tb/tb_countdown_controller.sv
// Scoreboard bench for countdown_controller with a modelled
// seconds datapath and a 4-cycle prescaler.
module tb_countdown_controller;

  typedef struct {
    int st;
    int rl;
    int cnt;
    int len;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, pause, abort;
  logic [3:0] rounds;
  logic       tick, count_zero;
  logic       count_load, count_enable, tick_clear;
  logic [3:0] rounds_left;
  logic       busy, ledr9_finished;
  logic [2:0] db_state;

  int         period = 3;
  int         presc = 0;
  logic [3:0] count = 4'd0;
  logic       ptick;
  logic       inj_tick = 1'b0;

  int checks = 0;
  int failures = 0;
  exp_t q[$];
  int idx = 0;

  countdown_controller #(
    .ROUNDS_WIDTH(4),
    .DONE_HOLD_TICKS(2)
  ) dut (
    .clock(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .abort(abort),
    .rounds(rounds),
    .tick(tick),
    .count_zero(count_zero),
    .count_load(count_load),
    .count_enable(count_enable),
    .tick_clear(tick_clear),
    .rounds_left(rounds_left),
    .busy(busy),
    .ledr9_finished(ledr9_finished),
    .db_state(db_state)
  );

  always #5 clk = ~clk;

  assign ptick      = (presc == 3);
  assign tick       = ptick | inj_tick;
  assign count_zero = (count == 4'd0);

  // Datapath model: prescaler and down-counter.
  always @(posedge clk) begin
    if (tick_clear || ptick) presc <= 0;
    else presc <= presc + 1;
    if (count_load) count <= 4'(period);
    else if (count_enable && tick && count != 4'd0)
      count <= count - 4'd1;
  end

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic expect_st(int st, int rl, int cnt, int len);
    exp_t e;
    e.st  = st;
    e.rl  = rl;
    e.cnt = cnt;
    e.len = len;
    q.push_back(e);
  endtask

  // Monitor: every state change pops one expectation.
  initial begin
    int prev;
    int dwell;
    int cur_len;
    exp_t e;
    prev = 0;
    dwell = 0;
    cur_len = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (int'(db_state) != prev) begin
          if (cur_len != 0)
            chk($sformatf("dwell#%0d", idx), dwell, cur_len);
          if (q.size() == 0) begin
            chk("unexpected_state", int'(db_state), -1);
            cur_len = 0;
          end else begin
            e = q.pop_front();
            idx++;
            chk($sformatf("state#%0d", idx), int'(db_state), e.st);
            chk($sformatf("rleft#%0d", idx), int'(rounds_left), e.rl);
            if (e.cnt >= 0)
              chk($sformatf("count#%0d", idx), int'(count), e.cnt);
            cur_len = e.len;
          end
          dwell = 1;
          prev = int'(db_state);
        end else begin
          dwell++;
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_after_edge", int'(db_state), 1);
  endtask

  task automatic wait_state(int st, int max, string nm);
    int n = 0;
    while (int'(db_state) != st && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(db_state), st);
  endtask

  task automatic run_until_idle(output int lt);
    int n = 0;
    lt = 0;
    while (int'(db_state) != 0 && n < 400) begin
      if (ledr9_finished && tick) lt++;
      @(negedge clk);
      n++;
    end
    chk("reach_idle", int'(db_state), 0);
  endtask

  initial begin
    int lt;
    int n;
    int n_load;
    int prv;
    reset = 1'b1;
    start = 1'b1;
    pause = 1'b0;
    abort = 1'b0;
    rounds = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(db_state), 0);
    chk("rst_load", int'(count_load), 1);
    chk("rst_tclr", int'(tick_clear), 1);
    chk("rst_en", int'(count_enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_led", int'(ledr9_finished), 0);
    chk("rst_rleft", int'(rounds_left), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_held_no_run", int'(db_state), 0);
    start = 1'b0;
    @(negedge clk);

`ifndef COUNTDOWN_AUTO_REPEAT_EN
    // Two rounds of 3..0 then DONE for two ticks.
    rounds = 4'd2;
    period = 3;
    expect_st(1, 2, -1, 1);
    expect_st(2, 2, 3, 16);
    expect_st(4, 2, 0, 1);
    expect_st(1, 1, -1, 1);
    expect_st(2, 1, 3, 16);
    expect_st(4, 1, 0, 1);
    expect_st(0 + 5, 0, 0, 7);
    expect_st(0, 0, 0, 0);
    pulse_start();
    run_until_idle(lt);
    chk("done_ticks", lt, 2);
    repeat (2) @(negedge clk);
`endif

    // Abort held blocks a start edge in IDLE.
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_blocks_start", int'(db_state), 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    // Abort in RUN; rounds=0 counts as one.
    rounds = 4'd0;
    period = 3;
    expect_st(1, 1, -1, 1);
    expect_st(2, 1, 3, 3);
    expect_st(0, 0, -1, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_run_state", int'(db_state), 0);
    chk("abort_run_load", int'(count_load), 1);
    chk("abort_run_busy", int'(busy), 0);
    @(negedge clk);

    // Abort in PAUSED.
    rounds = 4'd3;
    expect_st(1, 3, -1, 1);
    expect_st(2, 3, 3, 1);
    expect_st(3, 3, -1, 1);
    expect_st(0, 0, -1, 0);
    pulse_start();
    @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pause = 1'b0;
    chk("abort_pause_state", int'(db_state), 0);
    chk("abort_pause_busy", int'(busy), 0);
    @(negedge clk);

    // rounds=0 gives one round; abort in DONE.
    rounds = 4'd0;
    expect_st(1, 1, -1, 1);
    expect_st(2, 1, 3, 16);
    expect_st(4, 1, 0, 1);
    expect_st(5, 0, 0, 1);
    expect_st(0, 0, -1, 0);
    pulse_start();
    wait_state(5, 100, "reach_done_one_round");
    chk("done_led", int'(ledr9_finished), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done_state", int'(db_state), 0);
    chk("abort_done_led", int'(ledr9_finished), 0);
    chk("abort_done_load", int'(count_load), 1);
    @(negedge clk);

`ifndef COUNTDOWN_AUTO_REPEAT_EN
    // Pause at count 2, then pause coinciding with tick at zero.
    rounds = 4'd1;
    period = 3;
    expect_st(1, 1, -1, 1);
    expect_st(2, 1, 3, 0);
    expect_st(3, 1, 2, 0);
    expect_st(2, 1, 2, 0);
    expect_st(3, 1, 0, 0);
    expect_st(2, 1, 0, 4);
    expect_st(4, 1, 0, 1);
    expect_st(5, 0, 0, 7);
    expect_st(0, 0, 0, 0);
    pulse_start();
    n = 0;
    while (count != 4'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_count2", int'(count), 2);
    pause = 1'b1;
    @(negedge clk);
    chk("paused_state", int'(db_state), 3);
    chk("paused_tclr", int'(tick_clear), 1);
    chk("paused_en", int'(count_enable), 0);
    for (int i = 0; i < 5; i++) begin
      inj_tick = 1'b1;
      @(negedge clk);
      inj_tick = 1'b0;
      @(negedge clk);
    end
    chk("paused_hold_state", int'(db_state), 3);
    chk("paused_hold_count", int'(count), 2);
    pause = 1'b0;
    @(negedge clk);
    chk("resume_state", int'(db_state), 2);
    n = 0;
    while (count == 4'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resume_full_second", n, 4);
    n = 0;
    while (!(count == 4'd0 && tick) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_zero_tick", int'(count_zero && tick), 1);
    pause = 1'b1;
    @(negedge clk);
    chk("pause_beats_end", int'(db_state), 3);
    @(negedge clk);
    pause = 1'b0;
    @(negedge clk);
    run_until_idle(lt);
    chk("pause_done_ticks", lt, 2);
    @(negedge clk);

    // Zero period; restart from DONE.
    period = 0;
    rounds = 4'd1;
    expect_st(1, 1, -1, 1);
    expect_st(2, 1, 0, 4);
    expect_st(4, 1, 0, 1);
    expect_st(5, 0, 0, 1);
    expect_st(1, 1, -1, 1);
    expect_st(2, 1, 0, 4);
    expect_st(4, 1, 0, 1);
    expect_st(5, 0, 0, 7);
    expect_st(0, 0, 0, 0);
    pulse_start();
    wait_state(5, 100, "zero_reach_done");
    pulse_start();
    run_until_idle(lt);
    chk("zero_done_ticks", lt, 2);
    @(negedge clk);
`else
    // Auto repeat: three full loops, abort in the fourth.
    period = 1;
    rounds = 4'd1;
    for (int i = 0; i < 3; i++) begin
      expect_st(1, 1, -1, 1);
      expect_st(2, 1, 1, 8);
      expect_st(4, 1, 0, 1);
      expect_st(5, 0, 0, 7);
    end
    expect_st(1, 1, -1, 1);
    expect_st(2, 1, -1, 0);
    expect_st(0, 0, -1, 0);
    pulse_start();
    n_load = 1;
    prv = int'(db_state);
    n = 0;
    while (n_load < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (int'(db_state) == 1 && prv != 1) n_load++;
      prv = int'(db_state);
    end
    chk("auto_loads", n_load, 4);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("auto_abort_state", int'(db_state), 0);
    @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
